// File: rtl/mem_byte_sequencer_pkg.sv
// mem_pkg: shared definitions for the byte sequencer.
// - state_t     : IDLE / XFER / DONE encoding of the transfer FSM
// - DEPTH_DEF   : default data-memory depth in bytes
// - AW_DEF      : default byte-address width (log2 of DEPTH_DEF)
// - lane_select : big-endian byte pick, index 0 -> bits [31:24]
// - lane_write  : big-endian byte replace, index 0 -> bits [31:24]
package mem_pkg;

  localparam int DEPTH_DEF = 32;
  localparam int AW_DEF    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte idx counts from the most significant lane (big-endian).
  function automatic logic [7:0] lane_select(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Replace byte idx (big-endian numbering) of word with b.
  function automatic logic [31:0] lane_write(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (idx)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      2'd3:    w[7:0]   = b;
      default: w = word;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_byte_sequencer_lane_mux.sv
// mem_byte_lane_mux: combinational big-endian byte-lane access.
// Ports:
//   word     in  32  source word
//   idx      in   2  byte index, 0 = bits [31:24]
//   byte_in  in   8  byte to insert at idx
//   byte_out out  8  byte idx of word
//   word_out out 32  word with byte idx replaced by byte_in
module mem_byte_lane_mux
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  idx,
  input  logic [7:0]  byte_in,
  output logic [7:0]  byte_out,
  output logic [31:0] word_out
);

  // Select and replace the addressed lane.
  always_comb begin
    byte_out = lane_select(word, idx);
    word_out = lane_write(word, idx, byte_in);
  end

endmodule

// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: turns one 32-bit load/store from EX/MEM into four
// sequential big-endian byte accesses on a byte-wide data memory.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   memRead_i, memWrite_i      load / store request (store wins if both)
//   ALUOut_i, WriteData_i      word byte address, store data
//   ReadData_o                 assembled load word, held until next load
//   stall_o                    pipeline freeze while transfer is pending
//   done_o, err_o              completion pulse, alignment/range fault pulse
//   mem_addr_o, mem_wdata_o    byte address / byte data to the memory
//   mem_we_o, mem_re_o         byte write / read enable
//   mem_rdata_i                combinational byte read data
module mem_byte_sequencer
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          memRead_i,
  input  logic          memWrite_i,
  input  logic [31:0]   ALUOut_i,
  input  logic [31:0]   WriteData_i,
  output logic [31:0]   ReadData_o,
  output logic          stall_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_wdata_o,
  output logic          mem_we_o,
  output logic          mem_re_o,
  input  logic [7:0]    mem_rdata_i
);

  state_t        state_r;
  logic [1:0]    cnt_r;
  logic [AW-1:0] base_r;
  logic          is_store_r;
  logic [31:0]   wdata_word_r;
  logic [31:0]   asm_r;
  logic [31:0]   read_data_r;
  logic          done_r;
  logic [AW-1:0] mem_addr_r;
  logic [7:0]    mem_wdata_r;
  logic          mem_we_r;
  logic          mem_re_r;

  logic          req_s;
  logic          fault_s;
  logic          accept_s;
  logic [31:0]   st_word_s;
  logic [1:0]    st_idx_s;
  logic [7:0]    st_byte_s;
  logic [31:0]   st_unused_s;
  logic [7:0]    ld_unused_s;
  logic [31:0]   asm_next_s;
  logic [AW-1:0] addr_next_s;

  // Request decode and fault detection in IDLE.
  always_comb begin
    req_s    = memRead_i | memWrite_i;
    fault_s  = (ALUOut_i[1:0] != 2'b00) || (ALUOut_i >= 32'(DEPTH));
    accept_s = (state_r == IDLE) && req_s && !fault_s && !rst_i;
  end

  // Memory outputs are registered, so the store path looks one byte ahead:
  // byte 0 of the incoming word on accept, byte cnt+1 during XFER.
  always_comb begin
    if (accept_s) begin
      st_word_s = WriteData_i;
      st_idx_s  = 2'd0;
    end else begin
      st_word_s = wdata_word_r;
      st_idx_s  = cnt_r + 2'd1;
    end
    addr_next_s = base_r + {{(AW-2){1'b0}}, cnt_r} + {{(AW-1){1'b0}}, 1'b1};
  end

  mem_byte_lane_mux u_store_mux (
    .word     (st_word_s),
    .idx      (st_idx_s),
    .byte_in  (8'h00),
    .byte_out (st_byte_s),
    .word_out (st_unused_s)
  );

  mem_byte_lane_mux u_load_mux (
    .word     (asm_r),
    .idx      (cnt_r),
    .byte_in  (mem_rdata_i),
    .byte_out (ld_unused_s),
    .word_out (asm_next_s)
  );

  // Transfer FSM with registered memory-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      cnt_r        <= 2'd0;
      base_r       <= '0;
      is_store_r   <= 1'b0;
      wdata_word_r <= 32'h0000_0000;
      asm_r        <= 32'h0000_0000;
      read_data_r  <= 32'h0000_0000;
      done_r       <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 8'h00;
      mem_we_r     <= 1'b0;
      mem_re_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            base_r       <= ALUOut_i[AW-1:0];
            is_store_r   <= memWrite_i;
            wdata_word_r <= WriteData_i;
            cnt_r        <= 2'd0;
            mem_addr_r   <= ALUOut_i[AW-1:0];
            mem_wdata_r  <= st_byte_s;
            mem_we_r     <= memWrite_i;
            mem_re_r     <= !memWrite_i;
            state_r      <= XFER;
          end else begin
            state_r <= IDLE;
          end
        end
        XFER: begin
          if (!is_store_r) begin
            asm_r <= asm_next_s;
          end else begin
            asm_r <= asm_r;
          end
          if (cnt_r == 2'd3) begin
            cnt_r    <= 2'd0;
            mem_we_r <= 1'b0;
            mem_re_r <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= DONE;
            // Last byte comes straight from the lane writer so the word is
            // complete on entry to DONE.
            if (!is_store_r) begin
              read_data_r <= asm_next_s;
            end else begin
              read_data_r <= read_data_r;
            end
          end else begin
            cnt_r       <= cnt_r + 2'd1;
            mem_addr_r  <= addr_next_s;
            mem_wdata_r <= st_byte_s;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= 2'd0;
          done_r   <= 1'b0;
          mem_we_r <= 1'b0;
          mem_re_r <= 1'b0;
        end
      endcase
    end
  end

  // Stall and fault pulses respond in the request cycle itself.
  always_comb begin
    if (rst_i) begin
      stall_o = 1'b0;
      err_o   = 1'b0;
    end else begin
      stall_o = accept_s || (state_r == XFER);
      err_o   = (state_r == IDLE) && req_s && fault_s;
    end
  end

  assign ReadData_o  = read_data_r;
  assign done_o      = done_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign mem_we_o    = mem_we_r;
  assign mem_re_o    = mem_re_r;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
module tb_mem_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] alu_out;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic        done;
  logic        err;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  mem_byte_sequencer #(.DEPTH(32), .AW(5)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .memRead_i   (mem_read),
    .memWrite_i  (mem_write),
    .ALUOut_i    (alu_out),
    .WriteData_i (write_data),
    .ReadData_o  (read_data),
    .stall_o     (stall),
    .done_o      (done),
    .err_o       (err),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_re_o    (mem_re),
    .mem_rdata_i (mem_rdata)
  );

  // Byte-wide data memory and the bench's own reference copy.
  logic [7:0] mem [0:31];
  logic [7:0] ref_mem [0:31];

  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic        is_load;
    logic [31:0] word;
  } txn_t;

  beat_t beat_q[$];
  txn_t  txn_q[$];

  // Memory-bus scoreboard.
  always @(negedge clk) begin
    if (mem_we === 1'b1 || mem_re === 1'b1) begin
      if (beat_q.size() == 0) begin
        check("unexpected_beat", {mem_we, mem_re, 25'd0, mem_addr}, 32'd0);
      end else begin
        beat_t b;
        b = beat_q.pop_front();
        check("beat_we", {31'd0, mem_we}, {31'd0, b.we});
        check("beat_re", {31'd0, mem_re}, {31'd0, !b.we});
        check("beat_addr", {27'd0, mem_addr}, {27'd0, b.addr});
        if (b.we) check("beat_wdata", {24'd0, mem_wdata}, {24'd0, b.data});
        else      check("beat_rdata", {24'd0, mem_rdata}, {24'd0, b.data});
      end
    end
  end

  // Completion scoreboard.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (txn_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        txn_t t;
        t = txn_q.pop_front();
        if (t.is_load) check("load_word", read_data, t.word);
      end
    end
  end

  // Push the scoreboard entries a non-faulting request will produce.
  task automatic expect_txn(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data);
    txn_t t;
    logic [4:0] a;
    if (rd || wr) begin
      for (int i = 0; i < 4; i++) begin
        beat_t b;
        a = addr[4:0] + 5'(i);
        b.we = wr;
        b.addr = a;
        if (wr) begin
          b.data = data[8*(3-i) +: 8];
          ref_mem[a] = b.data;
        end else begin
          b.data = ref_mem[a];
        end
        beat_q.push_back(b);
        t.word[8*(3-i) +: 8] = ref_mem[a];
      end
      t.is_load = !wr;
      if (wr) t.word = 32'd0;
      txn_q.push_back(t);
    end
  endtask

  // Drive one request and follow it to done_o; ends in the DONE cycle.
  task automatic transact(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic keep_rd);
    int  stalls;
    int  lat;
    bit  got_done;
    expect_txn(rd, wr, addr, data);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; alu_out = addr; write_data = data;
    stalls = 0; lat = -1; got_done = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) begin
        got_done = 1'b1;
        lat = c;
        check("done_stall_low", {31'd0, stall}, 32'd0);
      end else begin
        @(posedge clk); #1;
        mem_write = 1'b0;
        mem_read  = keep_rd;
      end
    end
    check("done_seen", {31'd0, got_done}, 32'd1);
    check("latency", lat, 32'd5);
    check("stall_cycles", stalls, 32'd5);
    if (!keep_rd) begin
      @(negedge clk);
      check("done_pulse_width", {31'd0, done}, 32'd0);
      check("idle_stall", {31'd0, stall}, 32'd0);
    end
  endtask

  // Faulting request: err in the request cycle, no stall and no access.
  task automatic fault_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] prev_rd);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; alu_out = addr; write_data = 32'h5555_AAAA;
    @(negedge clk);
    check("fault_err", {31'd0, err}, 32'd1);
    check("fault_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check("fault_err_pulse", {31'd0, err}, 32'd0);
    check("fault_no_access", {30'd0, mem_we, mem_re}, 32'd0);
    check("fault_readdata", read_data, prev_rd);
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; alu_out = 32'd0; write_data = 32'd0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    mem[4] = 8'h12; mem[5] = 8'h34; mem[6] = 8'h56; mem[7] = 8'h78;
    ref_mem[4] = 8'h12; ref_mem[5] = 8'h34; ref_mem[6] = 8'h56; ref_mem[7] = 8'h78;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {read_data}, 32'd0);
    check("reset_ctrl", {26'd0, stall, done, err, mem_we, mem_re, 1'b0}, 32'd0);
    check("reset_bus", {19'd0, mem_addr, mem_wdata}, 32'd0);

    // Reset during XFER at cnt=1 of a store to 16.
    begin
      beat_t b;
      b.we = 1'b1; b.addr = 5'd16; b.data = 8'hA1; beat_q.push_back(b);
      b.addr = 5'd17; b.data = 8'hB2; beat_q.push_back(b);
      ref_mem[16] = 8'hA1; ref_mem[17] = 8'hB2;
    end
    @(posedge clk); #1;
    mem_write = 1'b1; alu_out = 32'd16; write_data = 32'hA1B2_C3D4;
    @(posedge clk); #1;          // XFER cnt=0
    mem_write = 1'b0;
    @(posedge clk); #1;          // XFER cnt=1
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_outputs", read_data, 32'd0);
    check("midrst_ctrl", {27'd0, stall, done, err, mem_we, mem_re}, 32'd0);
    check("midrst_bus", {19'd0, mem_addr, mem_wdata}, 32'd0);
    check("midrst_state", {30'd0, dut.state_r}, 32'd0);
    check("midrst_mem", {mem[16], mem[17], mem[18], mem[19]},
          {8'hA1, 8'hB2, ref_mem[18], ref_mem[19]});

    transact(1'b0, 1'b1, 32'd8, 32'hDEAD_BEEF, 1'b0);
    check("store8_mem", {mem[8], mem[9], mem[10], mem[11]}, 32'hDEAD_BEEF);

    transact(1'b1, 1'b0, 32'd4, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("load_hold", read_data, 32'h1234_5678);

    fault_req(1'b1, 1'b0, 32'd6, 32'h1234_5678);
    fault_req(1'b0, 1'b1, 32'd32, 32'h1234_5678);
    fault_req(1'b0, 1'b1, 32'd1, 32'h1234_5678);

    transact(1'b0, 1'b1, 32'd28, 32'h0BAD_F00D, 1'b0);
    check("store28_mem", {mem[28], mem[29], mem[30], mem[31]}, 32'h0BAD_F00D);

    transact(1'b1, 1'b0, 32'd16, 32'd0, 1'b0);
    check("load16_partial", read_data, {8'hA1, 8'hB2, ref_mem[18], ref_mem[19]});

    // Both enables high -> store; the held load is taken in the next IDLE.
    transact(1'b1, 1'b1, 32'd0, 32'hCAFE_F00D, 1'b1);
    transact(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    check("b2b_load_word", read_data, 32'hCAFE_F00D);

    repeat (3) @(negedge clk);
    check("beats_drained", beat_q.size(), 32'd0);
    check("txns_drained", txn_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
